otter_mem_arbiter: RTL

- Shares the data port (port 2) of the OTTER dual-port byte-addressable memory between two requesters:
  - M0: CPU load/store unit.
  - M1: DMA / program loader.
- Sequences each access, including the one-cycle synchronous read and its size/sign slicing window.
- Returns read data to the owning requester with a valid pulse.
- Sits between the requesters and the memory data port; the instruction port is untouched.

---
 rtl/otter_mem_arbiter_if.sv | 27 ++
 rtl/otter_mem_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/otter_mem_arbiter_if.sv
// Requester-side bus of the OTTER data-port arbiter.
// The master modport is the requester (CPU LSU or DMA/loader).
// The slave modport is the arbiter.
interface otter_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [1:0]        size;
  logic              sign;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, din, size, sign,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, din, size, sign,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/otter_mem_arbiter.sv
// Two-requester arbiter for the OTTER memory data port (port 2).
// M0 is the CPU load/store unit and M1 is the DMA/program loader.
// Writes complete in the grant cycle. A read is granted in IDLE, and its
// sliced data returns in RD_WAIT. During RD_WAIT the address, size and sign
// are held so the memory's combinational slicing stays valid.
// Optional feature: define ARB_ROUND_ROBIN_EN for alternating priority.
// Without it, M0 has fixed priority over M1.
module otter_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  otter_mem_arbiter_if.slave  m0,
  otter_mem_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0]   mem_addr2,
  output logic [DATA_W-1:0]   mem_din2,
  output logic                mem_write2,
  output logic                mem_read2,
  output logic [1:0]          mem_size,
  output logic                mem_sign,
  input  logic [DATA_W-1:0]   mem_dout2,
  output logic                busy
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t            state, next_state;
  logic              owner_q;        // 0 = M0, 1 = M1
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic              any_req;
  logic              win_sel;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_din;
  logic [1:0]        win_size;
  logic              win_sign;
  logic              grant;
  logic              load_start;
  logic              gnt0, gnt1, rvalid0, rvalid1;

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr;  // preferred requester when both request

  // Hand preference to the requester that was not just granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ptr <= 1'b0;
    else if (grant) ptr <= ~win_sel;
  end

  // Use the pointer only when both requesters are asking.
  always_comb begin
    win_sel = (m0.req && m1.req) ? ptr : m1.req;
  end
`else
  // Use fixed priority: M0 always beats M1.
  always_comb begin
    win_sel = ~m0.req;
  end
`endif

  // Select the winner's payload and decide whether a grant happens now.
  always_comb begin
    any_req    = m0.req | m1.req;
    win_we     = win_sel ? m1.we   : m0.we;
    win_addr   = win_sel ? m1.addr : m0.addr;
    win_din    = win_sel ? m1.din  : m0.din;
    win_size   = win_sel ? m1.size : m0.size;
    win_sign   = win_sel ? m1.sign : m0.sign;
    grant      = (state == IDLE) && any_req && !rst;
    load_start = grant && !win_we;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // Hold the FSM state and latch the read context when a load is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
    end else begin
      state <= next_state;
      if (load_start) begin
        owner_q <= win_sel;
        addr_q  <= win_addr;
        size_q  <= win_size;
        sign_q  <= win_sign;
      end
    end
  end

  // Keep each requester's last load result until its next load completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state == RD_WAIT) begin
      if (owner_q) rdata1_q <= mem_dout2;
      else         rdata0_q <= mem_dout2;
    end
  end

  // Compute next state and drive the memory port, grants and read handshake.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    next_state = state;
    mem_addr2  = '0;
    mem_din2   = '0;
    mem_write2 = 1'b0;
    mem_read2  = 1'b0;
    mem_size   = '0;
    mem_sign   = 1'b0;
    busy       = 1'b0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    rvalid0    = 1'b0;
    rvalid1    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt0      = ~win_sel;
            gnt1      = win_sel;
            mem_addr2 = win_addr;
            mem_din2  = win_din;
            mem_size  = win_size;
            mem_sign  = win_sign;
            if (win_we) begin
              mem_write2 = 1'b1;
            end else begin
              mem_read2  = 1'b1;
              next_state = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          mem_addr2  = addr_q;
          mem_size   = size_q;
          mem_sign   = sign_q;
          busy       = 1'b1;
          rvalid0    = ~owner_q;
          rvalid1    = owner_q;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rvalid0;
  assign m1.rvalid = rvalid1;
  // Read data passes straight through in RD_WAIT, then the held copy is used.
  assign m0.rdata  = rvalid0 ? mem_dout2 : rdata0_q;
  assign m1.rdata  = rvalid1 ? mem_dout2 : rdata1_q;

endmodule
